mc_ctrl_hs: RTL and testbench

- Parametrised multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback over a variable-latency memory with a req/ack handshake and a programmable timeout.
- Every datapath control field is a pure function of the current state and the latched instruction class. No stale field values carry over from previous states.
- The block drives the multicycle datapath: PC, IR, register file, ALU, extender, byte-enable unit and PC mux.

---
 rtl/mc_ctrl_hs.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control FSM (IF/ID/EX/MEM/WB/TRAP) driving the
// PC, IR, register file, ALU, extender, byte-enable unit and PC mux over a
// req/ack memory with a programmable wait timeout (TIMEOUT=0 disables it).
// Optional feature macro: MC_CTRL_TRAP_EN (illegal opcodes and bus timeouts
// load the trap vector through the TRAP state; otherwise illegal opcodes are
// NOPs and timeouts refetch or abandon the instruction).
module mc_ctrl_hs #(
    parameter int TIMEOUT = 15,
    parameter int TW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic [4:0] rt_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       reg_write_o,
    output logic [1:0] alusrc_a_o,
    output logic [2:0] alusrc_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] ext_op_o,
    output logic [1:0] pc_source_o,
    output logic [1:0] regdst_o,
    output logic [2:0] memtoreg_o,
    output logic [2:0] branch_o,
    output logic [2:0] be_op_o,
    output logic       retire_o,
    output logic       bus_err_o,
    output logic       trap_o
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

    typedef enum logic [3:0] {
        C_RALU, C_SHIFT, C_JR, C_JALR, C_J, C_JAL,
        C_BR, C_LOAD, C_STORE, C_IMM, C_LUI, C_ILL
    } iclass_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] alusrc_a;
        logic [2:0] alusrc_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic [1:0] pc_source;
        logic [1:0] regdst;
        logic [2:0] memtoreg;
        logic [2:0] branch;
        logic [2:0] be_op;
        logic       retire;
        logic       bus_err;
        logic       trap;
    } ctrl_t;

    localparam bit            TO_EN     = (TIMEOUT != 0);
    localparam logic [TW-1:0] LAST_WAIT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

`ifdef MC_CTRL_TRAP_EN
    localparam state_t ABORT_STATE = S_TRAP;
`else
    localparam state_t ABORT_STATE = S_IF;
`endif

    state_t        state, state_next;
    iclass_t       dec_cls, cls_q;
    logic [5:0]    op_q;
    logic          rt0_q;
    logic [TW-1:0] wait_cnt;
    logic          expire;
    ctrl_t         ctl;

    // Byte-enable code for the load/store opcode held in the IR.
    function automatic logic [2:0] be_code(input logic [5:0] op);
        case (op)
            6'h29:   return 3'b001;
            6'h28:   return 3'b010;
            6'h23:   return 3'b011;
            6'h25:   return 3'b100;
            6'h21:   return 3'b101;
            6'h24:   return 3'b110;
            6'h20:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Branch condition code; REGIMM (01) splits on rt[0] (bltz/bgez).
    function automatic logic [2:0] br_code(input logic [5:0] op, input logic rt0);
        case (op)
            6'h05:   return 3'b001;
            6'h07:   return 3'b010;
            6'h06:   return 3'b100;
            6'h01:   return rt0 ? 3'b101 : 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // {alu_op, ext_op} for the immediate-ALU opcodes.
    function automatic logic [4:0] imm_code(input logic [5:0] op);
        case (op)
            6'h0C:   return {3'b001, 2'b00};
            6'h0D:   return {3'b011, 2'b00};
            6'h0E:   return {3'b100, 2'b00};
            6'h0A:   return {3'b110, 2'b01};
            6'h0B:   return {3'b111, 2'b01};
            default: return {3'b000, 2'b01};
        endcase
    endfunction

    // Instruction class decode from the IR fields, sampled during ID.
    always_comb begin
        dec_cls = C_ILL;
        case (opcode_i)
            6'h00: begin
                case (funct_i)
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: dec_cls = C_RALU;
                    6'h00, 6'h02, 6'h03:                      dec_cls = C_SHIFT;
                    6'h08:                                    dec_cls = C_JR;
                    6'h09:                                    dec_cls = C_JALR;
                    default:                                  dec_cls = C_ILL;
                endcase
            end
            6'h01:                                    dec_cls = (rt_i == 5'd0 || rt_i == 5'd1) ? C_BR : C_ILL;
            6'h02:                                    dec_cls = C_J;
            6'h03:                                    dec_cls = C_JAL;
            6'h04, 6'h05, 6'h06, 6'h07:               dec_cls = C_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: dec_cls = C_IMM;
            6'h0F:                                    dec_cls = C_LUI;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:        dec_cls = C_LOAD;
            6'h28, 6'h29, 6'h2B:                      dec_cls = C_STORE;
            default:                                  dec_cls = C_ILL;
        endcase
    end

    // Timeout fires on the last allowed wait cycle of IF or MEM unless acked.
    assign expire = TO_EN && (state == S_IF || state == S_MEM) && !mem_ack_i
                    && (wait_cnt == LAST_WAIT);

    // State register, latched instruction class and request wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IF;
            cls_q    <= C_ILL;
            op_q     <= '0;
            rt0_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
            if (state == S_ID) begin
                cls_q <= dec_cls;
                op_q  <= opcode_i;
                rt0_q <= rt_i[0];
            end
            if ((state == S_IF || state == S_MEM) && !mem_ack_i && !expire)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Next-state and control fields as a pure function of state and class.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a value
        // held over, which would otherwise infer latches.
        state_next = state;
        ctl        = '0;
        case (state)
            S_IF: begin
                ctl.mem_req  = 1'b1;
                ctl.alusrc_b = 3'b001;
                ctl.ir_write = mem_ack_i;
                ctl.pc_write = mem_ack_i;
                if (mem_ack_i) begin
                    state_next = S_ID;
                end else if (expire) begin
                    ctl.bus_err = 1'b1;
                    state_next  = ABORT_STATE;
                end
            end
            S_ID: begin
                ctl.alusrc_b = 3'b011;
                ctl.ext_op   = 2'b01;
                if (dec_cls != C_ILL) begin
                    state_next = S_EX;
                end else begin
`ifdef MC_CTRL_TRAP_EN
                    state_next = S_TRAP;
`else
                    ctl.retire = 1'b1;
                    state_next = S_IF;
`endif
                end
            end
            S_EX: begin
                state_next = S_IF;
                case (cls_q)
                    C_RALU, C_SHIFT: begin
                        ctl.alusrc_a = (cls_q == C_SHIFT) ? 2'b10 : 2'b01;
                        ctl.alu_op   = 3'b010;
                        state_next   = S_WB;
                    end
                    C_J, C_JAL: begin
                        ctl.pc_write  = 1'b1;
                        ctl.pc_source = 2'b10;
                        ctl.retire    = 1'b1;
                        if (cls_q == C_JAL) begin
                            ctl.reg_write = 1'b1;
                            ctl.regdst    = 2'b10;
                            ctl.memtoreg  = 3'b010;
                        end
                    end
                    C_JR, C_JALR: begin
                        ctl.pc_write  = 1'b1;
                        ctl.pc_source = 2'b11;
                        ctl.retire    = 1'b1;
                        if (cls_q == C_JALR) begin
                            ctl.reg_write = 1'b1;
                            ctl.regdst    = 2'b01;
                            ctl.memtoreg  = 3'b010;
                        end
                    end
                    C_BR: begin
                        ctl.alusrc_a      = 2'b01;
                        ctl.alu_op        = 3'b101;
                        ctl.pc_write_cond = 1'b1;
                        ctl.pc_source     = 2'b01;
                        ctl.branch        = br_code(op_q, rt0_q);
                        ctl.retire        = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        ctl.alusrc_a = 2'b01;
                        ctl.alusrc_b = 3'b010;
                        ctl.ext_op   = (op_q == 6'h24 || op_q == 6'h25) ? 2'b00 : 2'b01;
                        state_next   = S_MEM;
                    end
                    C_IMM: begin
                        ctl.alusrc_a                = 2'b01;
                        ctl.alusrc_b                = 3'b010;
                        {ctl.alu_op, ctl.ext_op}    = imm_code(op_q);
                        state_next                  = S_WB;
                    end
                    C_LUI: begin
                        ctl.reg_write = 1'b1;
                        ctl.memtoreg  = 3'b100;
                        ctl.ext_op    = 2'b10;
                        ctl.retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
                ctl.mem_we  = (cls_q == C_STORE);
                ctl.be_op   = be_code(op_q);
                if (mem_ack_i) begin
                    ctl.retire = (cls_q == C_STORE);
                    state_next = (cls_q == C_STORE) ? S_IF : S_WB;
                end else if (expire) begin
                    ctl.bus_err = 1'b1;
                    state_next  = ABORT_STATE;
                end
            end
            S_WB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                ctl.regdst    = (cls_q == C_RALU || cls_q == C_SHIFT) ? 2'b01 : 2'b00;
                ctl.memtoreg  = (cls_q == C_LOAD) ? 3'b001 : 3'b000;
                state_next    = S_IF;
            end
            S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                ctl.trap     = 1'b1;
                ctl.pc_write = 1'b1;
`endif
                state_next = S_IF;
            end
            default: state_next = S_IF;
        endcase
    end

    // Outputs are forced low while reset is asserted, so an in-flight
    // request drops as soon as rst_n falls rather than at the next edge.
    assign {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
            reg_write_o, alusrc_a_o, alusrc_b_o, alu_op_o, ext_op_o, pc_source_o,
            regdst_o, memtoreg_o, branch_o, be_op_o, retire_o, bus_err_o,
            trap_o} = rst_n ? ctl : '0;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb_mc_ctrl_hs: directed plus random instruction streams for mc_ctrl_hs,
// compared cycle by cycle against a mnemonic-level reference model.
module tb_mc_ctrl_hs;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] alusrc_a;
        logic [2:0] alusrc_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic [1:0] pc_source;
        logic [1:0] regdst;
        logic [2:0] memtoreg;
        logic [2:0] branch;
        logic [2:0] be_op;
        logic       retire;
        logic       bus_err;
        logic       trap;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] alusrc_a, ext_op, pc_source, regdst;
    logic [2:0] alusrc_b, alu_op, memtoreg, branch, be_op;
    logic       retire, bus_err, trap;
    ctrl_t      obs;

    int checks = 0;
    int errors = 0;
    int cur_cyc;
    int ret_cyc;
    bit load_ir;
    logic [5:0] nxt_op;
    logic [4:0] nxt_rt;
    logic [5:0] nxt_fn;

    logic [5:0] op_pool [24] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                 6'h05, 6'h06, 6'h07, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h29, 6'h3F};

    always #5 clk = ~clk;

    mc_ctrl_hs #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .rt_i(rt), .funct_i(funct),
        .mem_ack_i(mem_ack), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
        .reg_write_o(reg_write), .alusrc_a_o(alusrc_a), .alusrc_b_o(alusrc_b),
        .alu_op_o(alu_op), .ext_op_o(ext_op), .pc_source_o(pc_source), .regdst_o(regdst),
        .memtoreg_o(memtoreg), .branch_o(branch), .be_op_o(be_op), .retire_o(retire),
        .bus_err_o(bus_err), .trap_o(trap)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write,
                  alusrc_a, alusrc_b, alu_op, ext_op, pc_source, regdst, memtoreg,
                  branch, be_op, retire, bus_err, trap};

    // Mnemonic string for an encoding; unimplemented encodings map to ill.
    function automatic string mnem(input logic [5:0] op, input logic [4:0] r, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h00: return "sll";   6'h02: return "srl";  6'h03: return "sra";
                6'h04: return "sllv";  6'h06: return "srlv"; 6'h07: return "srav";
                6'h08: return "jr";    6'h09: return "jalr";
                6'h20: return "add";   6'h21: return "addu"; 6'h22: return "sub";
                6'h23: return "subu";  6'h24: return "and";  6'h25: return "or";
                6'h26: return "xor";   6'h27: return "nor";  6'h2A: return "slt";
                6'h2B: return "sltu";
                default: return "ill";
            endcase
        end
        if (op == 6'h01) return (r == 5'd0) ? "bltz" : (r == 5'd1) ? "bgez" : "ill";
        case (op)
            6'h02: return "j";     6'h03: return "jal";   6'h04: return "beq";
            6'h05: return "bne";   6'h06: return "blez";  6'h07: return "bgtz";
            6'h08: return "addi";  6'h09: return "addiu"; 6'h0A: return "slti";
            6'h0B: return "sltiu"; 6'h0C: return "andi";  6'h0D: return "ori";
            6'h0E: return "xori";  6'h0F: return "lui";   6'h20: return "lb";
            6'h21: return "lh";    6'h23: return "lw";    6'h24: return "lbu";
            6'h25: return "lhu";   6'h28: return "sb";    6'h29: return "sh";
            6'h2B: return "sw";
            default: return "ill";
        endcase
    endfunction

    function automatic string grp(input string m);
        case (m)
            "sll", "srl", "sra": return "shift";
            "sllv", "srlv", "srav", "add", "addu", "sub", "subu", "and", "or",
            "xor", "nor", "slt", "sltu": return "ralu";
            "jr", "jalr", "j", "jal", "lui": return m;
            "bltz", "bgez", "beq", "bne", "blez", "bgtz": return "br";
            "addi", "addiu", "slti", "sltiu", "andi", "ori", "xori": return "imm";
            "lb", "lh", "lw", "lbu", "lhu": return "load";
            "sb", "sh", "sw": return "store";
            default: return "ill";
        endcase
    endfunction

    // Expected control bundle for one cycle of a given phase of instruction m.
    function automatic ctrl_t expect_ctrl(input string ph, input string m, input bit ack, input bit tmo);
        ctrl_t e = '0;
        string g = grp(m);
        case (ph)
            "if": begin
                e.mem_req = 1; e.alusrc_b = 3'd1; e.ir_write = ack; e.pc_write = ack; e.bus_err = tmo;
            end
            "id": begin
                e.alusrc_b = 3'd3; e.ext_op = 2'd1;
`ifndef MC_CTRL_TRAP_EN
                if (g == "ill") e.retire = 1;
`endif
            end
            "ex": begin
                case (g)
                    "ralu":  begin e.alusrc_a = 2'd1; e.alu_op = 3'd2; end
                    "shift": begin e.alusrc_a = 2'd2; e.alu_op = 3'd2; end
                    "j":     begin e.pc_write = 1; e.pc_source = 2'd2; e.retire = 1; end
                    "jal":   begin e.pc_write = 1; e.pc_source = 2'd2; e.retire = 1;
                                   e.reg_write = 1; e.regdst = 2'd2; e.memtoreg = 3'd2; end
                    "jr":    begin e.pc_write = 1; e.pc_source = 2'd3; e.retire = 1; end
                    "jalr":  begin e.pc_write = 1; e.pc_source = 2'd3; e.retire = 1;
                                   e.reg_write = 1; e.regdst = 2'd1; e.memtoreg = 3'd2; end
                    "br": begin
                        e.alusrc_a = 2'd1; e.alu_op = 3'd5; e.pc_write_cond = 1;
                        e.pc_source = 2'd1; e.retire = 1;
                        case (m)
                            "bne": e.branch = 3'd1;  "bgtz": e.branch = 3'd2;
                            "bltz": e.branch = 3'd3; "blez": e.branch = 3'd4;
                            "bgez": e.branch = 3'd5; default: e.branch = 3'd0;
                        endcase
                    end
                    "load", "store": begin
                        e.alusrc_a = 2'd1; e.alusrc_b = 3'd2;
                        e.ext_op = (m == "lbu" || m == "lhu") ? 2'd0 : 2'd1;
                    end
                    "imm": begin
                        e.alusrc_a = 2'd1; e.alusrc_b = 3'd2;
                        case (m)
                            "andi":  begin e.alu_op = 3'd1; e.ext_op = 2'd0; end
                            "ori":   begin e.alu_op = 3'd3; e.ext_op = 2'd0; end
                            "xori":  begin e.alu_op = 3'd4; e.ext_op = 2'd0; end
                            "slti":  begin e.alu_op = 3'd6; e.ext_op = 2'd1; end
                            "sltiu": begin e.alu_op = 3'd7; e.ext_op = 2'd1; end
                            default: begin e.alu_op = 3'd0; e.ext_op = 2'd1; end
                        endcase
                    end
                    "lui": begin e.reg_write = 1; e.memtoreg = 3'd4; e.ext_op = 2'd2; e.retire = 1; end
                    default: ;
                endcase
            end
            "mem": begin
                e.mem_req = 1; e.iord = 1; e.mem_we = (g == "store");
                e.retire = (g == "store") && ack; e.bus_err = tmo;
                case (m)
                    "sh": e.be_op = 3'd1;  "sb": e.be_op = 3'd2;  "lw": e.be_op = 3'd3;
                    "lhu": e.be_op = 3'd4; "lh": e.be_op = 3'd5;  "lbu": e.be_op = 3'd6;
                    "lb": e.be_op = 3'd7;  default: e.be_op = 3'd0;
                endcase
            end
            "wb": begin
                e.reg_write = 1; e.retire = 1;
                e.regdst = (g == "ralu" || g == "shift") ? 2'd1 : 2'd0;
                e.memtoreg = (g == "load") ? 3'd1 : 3'd0;
            end
            "trap": begin e.trap = 1; e.pc_write = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs after the falling edge, then compare.
    task automatic cycle(input string tag, input ctrl_t e, input bit a);
        @(negedge clk);
        if (load_ir) begin
            opcode = nxt_op; rt = nxt_rt; funct = nxt_fn; load_ir = 0;
        end
        mem_ack = a;
        #1;
        cur_cyc++;
        if (retire === 1'b1 && ret_cyc == 0) ret_cyc = cur_cyc;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cur_cyc, obs, e);
        end
    endtask

    task automatic check_lat(input string tag, input int want);
        checks++;
        assert (ret_cyc === want) else begin
            errors++;
            $error("FAIL %s retire_cycle observed=%0d expected=%0d", tag, ret_cyc, want);
        end
    endtask

    task automatic abort_tail(input string m);
`ifdef MC_CTRL_TRAP_EN
        cycle({m, ":trap"}, expect_ctrl("trap", m, 0, 0), 0);
`endif
        check_lat({m, ":no_retire"}, 0);
    endtask

    // Runs one instruction with if_w fetch waits and mem_w memory waits.
    task automatic run_instr(input logic [5:0] op, input logic [4:0] r, input logic [5:0] fn,
                             input int if_w, input int mem_w);
        string m = mnem(op, r, fn);
        string g = grp(m);
        bit a, tmo;
        nxt_op = op; nxt_rt = r; nxt_fn = fn; load_ir = 1;
        cur_cyc = 0; ret_cyc = 0;
        for (int w = 0; w < 64; w++) begin
            a = (w == if_w);
            tmo = !a && (w == TIMEOUT - 1);
            cycle({m, ":if"}, expect_ctrl("if", m, a, tmo), a);
            if (tmo) begin abort_tail(m); return; end
            if (a) break;
        end
        cycle({m, ":id"}, expect_ctrl("id", m, 0, 0), 0);
        if (g == "ill") begin
`ifdef MC_CTRL_TRAP_EN
            abort_tail(m);
`else
            check_lat({m, ":latency"}, 2 + if_w);
`endif
            return;
        end
        cycle({m, ":ex"}, expect_ctrl("ex", m, 0, 0), 0);
        if (g == "ralu" || g == "shift" || g == "imm") begin
            cycle({m, ":wb"}, expect_ctrl("wb", m, 0, 0), 0);
            check_lat({m, ":latency"}, 4 + if_w);
            return;
        end
        if (g != "load" && g != "store") begin
            check_lat({m, ":latency"}, 3 + if_w);
            return;
        end
        for (int w = 0; w < 64; w++) begin
            a = (w == mem_w);
            tmo = !a && (w == TIMEOUT - 1);
            cycle({m, ":mem"}, expect_ctrl("mem", m, a, tmo), a);
            if (tmo) begin abort_tail(m); return; end
            if (a) break;
        end
        if (g == "store") begin
            check_lat({m, ":latency"}, 4 + if_w + mem_w);
            return;
        end
        cycle({m, ":wb"}, expect_ctrl("wb", m, 0, 0), 0);
        check_lat({m, ":latency"}, 5 + if_w + mem_w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2;
        rst_n = 0; mem_ack = 0; opcode = '0; rt = '0; funct = '0; load_ir = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        assert (obs === ctrl_t'('0)) else begin
            errors++; $error("FAIL reset observed=%h expected=0", obs);
        end
        @(posedge clk); #1 rst_n = 1;

        run_instr(6'h00, 5'd0, 6'h21, 2, 0);   // addu, fetch acked on 3rd request
        run_instr(6'h00, 5'd3, 6'h21, 0, 0);   // addu zero-wait
        run_instr(6'h00, 5'd0, 6'h00, 0, 0);   // sll zero-wait
        run_instr(6'h20, 5'd2, 6'h11, 0, 2);   // lb, two memory waits
        run_instr(6'h01, 5'd0, 6'h00, 0, 0);   // bltz
        run_instr(6'h01, 5'd1, 6'h00, 0, 0);   // bgez
        run_instr(6'h23, 5'd0, 6'h00, 0, 9);   // lw, memory never acks
        run_instr(6'h0D, 5'd0, 6'h00, 9, 0);   // fetch never acks
        run_instr(6'h3F, 5'd0, 6'h00, 0, 0);   // illegal opcode
        run_instr(6'h0D, 5'd0, 6'h00, 3, 0);   // ori, ack on the expiry cycle
        run_instr(6'h2B, 5'd0, 6'h00, 1, 3);   // sw, ack on the expiry cycle
        run_instr(6'h0F, 5'd0, 6'h00, 0, 0);   // lui
        run_instr(6'h03, 5'd0, 6'h00, 0, 0);   // jal
        run_instr(6'h00, 5'd0, 6'h09, 1, 0);   // jalr

        // Asynchronous reset in the middle of a fetch handshake.
        @(negedge clk); mem_ack = 0; #1;
        checks++;
        assert (mem_req === 1'b1) else begin
            errors++; $error("FAIL pre_reset_req observed=%b expected=1", mem_req);
        end
        #1 rst_n = 0; #1;
        checks++;
        assert (obs === ctrl_t'('0)) else begin
            errors++; $error("FAIL async_reset observed=%h expected=0", obs);
        end
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 200; i++) begin
            r1 = $urandom_range(0, 9);
            r2 = $urandom_range(0, 9);
            run_instr(op_pool[$urandom_range(0, 23)], 5'($urandom_range(0, 3)),
                      6'($urandom_range(0, 63)),
                      (r1 == 9) ? TIMEOUT : r1 % 4, (r2 == 9) ? TIMEOUT : r2 % 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
